// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stepper_pkg
// Brief    : Shared state and direction encodings for the stepper command path
// Revision : 1.0 - initial release
// ============================================================================
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Width needed to hold a ramp index in 0..ramp_steps
  function automatic int acc_width(input int ramp_steps);
    return (ramp_steps < 1) ? 1 : $clog2(ramp_steps + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_ramp_timer.sv
`default_nettype none
// ============================================================================
// Module   : step_ramp_timer
// Brief    : Step period timer with trapezoidal ramp index and terminal count
// Revision : 1.0 - initial release
// ============================================================================
module step_ramp_timer
  import stepper_pkg::*;
#(
  parameter int POS_W       = 16,
  parameter int DIV_W       = 20,
  parameter int PERIOD_SLOW = 400000,
  parameter int PERIOD_FAST = 50000,
  parameter int RAMP_STEPS  = 8,
  parameter int ACC_W       = acc_width(RAMP_STEPS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             run,
  input  logic             step,
  input  logic             settle_load,
  input  logic [POS_W-1:0] remaining,
  output logic             tick,
  output logic [ACC_W-1:0] acc_idx
);

  localparam int               DELTA         = (PERIOD_SLOW - PERIOD_FAST) / RAMP_STEPS;
  localparam logic [ACC_W-1:0] c_ramp_max    = ACC_W'(RAMP_STEPS);
  localparam logic [ACC_W-1:0] c_acc_one     = ACC_W'(1);
  localparam logic [DIV_W-1:0] c_period_slow = DIV_W'(PERIOD_SLOW);
  localparam logic [DIV_W-1:0] c_one         = DIV_W'(1);

  logic [DIV_W-1:0] r_timer;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;

  function automatic logic [DIV_W-1:0] period_of(input logic [ACC_W-1:0] idx);
    return DIV_W'(PERIOD_SLOW - DELTA * int'(idx));
  endfunction

  // Decelerate once the steps left no longer cover the ramp already climbed
  always_comb begin
    w_acc_next = r_acc;
    if (remaining <= POS_W'(r_acc)) begin
      if (r_acc != '0) w_acc_next = r_acc - c_acc_one;
    end else if (r_acc < c_ramp_max) begin
      w_acc_next = r_acc + c_acc_one;
    end
  end

  assign tick    = run && (r_timer == c_one);
  assign acc_idx = r_acc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_timer <= '0;
      r_acc   <= '0;
    end else if (start) begin
      r_timer <= c_period_slow;
      r_acc   <= '0;
    end else begin
      if (step) r_acc <= w_acc_next;
      if (settle_load)  r_timer <= c_period_slow;
      else if (step)    r_timer <= period_of(w_acc_next);
      else if (run)     r_timer <= r_timer - c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/step_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : step_motion_ctrl
// Brief    : Move-command stage issuing ramped step pulses to the coil sequencer.
//            Optional STEP_SOFT_LIMIT_EN adds POS_MIN/POS_MAX limits and limit_hit.
// Revision : 1.0 - initial release
// ============================================================================
module step_motion_ctrl
  import stepper_pkg::*;
#(
  parameter int POS_W       = 16,
  parameter int DIV_W       = 20,
  parameter int PERIOD_SLOW = 400000,
  parameter int PERIOD_FAST = 50000,
  parameter int RAMP_STEPS  = 8
`ifdef STEP_SOFT_LIMIT_EN
  ,
  parameter int POS_MIN     = -32768,
  parameter int POS_MAX     = 32767
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [POS_W-1:0] cmd_steps,
  input  logic             abort,
  output logic             step_pulse,
  output logic             sentido,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
`ifdef STEP_SOFT_LIMIT_EN
  ,
  output logic             limit_hit
`endif
);

  localparam int ACC_W = acc_width(RAMP_STEPS);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sentido;
  logic [POS_W-1:0] r_position;
  logic [POS_W-1:0] r_remaining;
  logic [POS_W-1:0] w_acc_ext;
  logic [POS_W-1:0] w_rem_clip;
  logic [POS_W-1:0] w_rem_next;
  logic [ACC_W-1:0] w_acc_idx;
  logic             w_tick;
  logic             w_block;
  logic             w_step;
  logic             w_accept;
  logic             w_in_move;
  logic             w_run;
  logic             w_start;
  logic             w_settle_load;

  assign w_accept  = cmd_valid && (r_state == IDLE);
  assign w_in_move = (r_state == MOVE);
  assign w_run     = w_in_move || (r_state == SETTLE);

  // Abort clips the budget to what the current ramp needs to come down to a stop
  assign w_acc_ext  = POS_W'(w_acc_idx) + POS_W'(1);
  assign w_rem_clip = (w_in_move && abort && (r_remaining > w_acc_ext)) ? w_acc_ext : r_remaining;
  assign w_step     = w_in_move && w_tick && !w_block;
  assign w_rem_next = w_step ? (w_rem_clip - POS_W'(1)) : w_rem_clip;

`ifdef STEP_SOFT_LIMIT_EN
  localparam logic [POS_W-1:0] c_pos_min = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] c_pos_max = POS_W'(POS_MAX);

  logic r_limit_hit;

  assign w_block = w_in_move && w_tick &&
                   ((r_sentido == DIR_FWD) ? ($signed(r_position) >= $signed(c_pos_max))
                                           : ($signed(r_position) <= $signed(c_pos_min)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_limit_hit <= 1'b0;
    else if (w_accept) r_limit_hit <= 1'b0;
    else if (w_block)  r_limit_hit <= 1'b1;
  end

  assign limit_hit = r_limit_hit;
`else
  assign w_block = 1'b0;
`endif

  step_ramp_timer #(
    .POS_W       (POS_W),
    .DIV_W       (DIV_W),
    .PERIOD_SLOW (PERIOD_SLOW),
    .PERIOD_FAST (PERIOD_FAST),
    .RAMP_STEPS  (RAMP_STEPS),
    .ACC_W       (ACC_W)
  ) u_ramp (
    .CLK         (CLK),
    .RST         (RST),
    .start       (w_start),
    .run         (w_run),
    .step        (w_step),
    .settle_load (w_settle_load),
    .remaining   (w_rem_next),
    .tick        (w_tick),
    .acc_idx     (w_acc_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_settle_load = 1'b0;
    cmd_ready     = (r_state == IDLE);
    busy          = w_run;
    done          = (r_state == DONE);
    step_pulse    = w_step;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_start      = 1'b1;
          w_state_next = (cmd_steps != '0) ? MOVE : DONE;
        end
      end
      MOVE: begin
        if (w_block || (w_step && (w_rem_next == '0))) begin
          w_settle_load = 1'b1;
          w_state_next  = SETTLE;
        end
      end
      SETTLE:  if (w_tick) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sentido   <= DIR_FWD;
      r_remaining <= '0;
      r_position  <= '0;
    end else begin
      if (w_accept) begin
        r_sentido   <= cmd_dir;
        r_remaining <= cmd_steps;
      end else if (w_in_move) begin
        r_remaining <= w_rem_next;
      end
      if (w_step)
        r_position <= (r_sentido == DIR_FWD) ? (r_position + POS_W'(1)) : (r_position - POS_W'(1));
    end
  end

  assign sentido  = r_sentido;
  assign position = r_position;

endmodule
`default_nettype wire

// File: tb/tb_step_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_motion_ctrl
// Brief    : Directed self-checking bench for step_motion_ctrl against a
//            pulse-schedule model planned per command
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_motion_ctrl;

  localparam int TB_SLOW    = 20;
  localparam int TB_FAST    = 4;
  localparam int TB_RS      = 4;
  localparam int TB_POS_MIN = -32768;
  localparam int TB_POS_MAX = 5;
  localparam int MAXC       = 3000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic        abort = 1'b0;
  logic        cmd_ready, step_pulse, sentido, busy, done;
  logic [15:0] position;
`ifdef STEP_SOFT_LIMIT_EN
  logic        limit_hit;
  logic        exp_limit [MAXC];
`endif

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          per [TB_RS+1];
  logic        exp_pulse [MAXC];
  logic        exp_done [MAXC];
  logic        exp_busy [MAXC];
  logic        exp_ready [MAXC];
  logic        exp_sentido [MAXC];
  logic [15:0] exp_pos [MAXC];
  int          pulse_log [$];
  int          done_log [$];
  int          ivs [10];

  step_motion_ctrl #(
    .POS_W       (16),
    .DIV_W       (20),
    .PERIOD_SLOW (TB_SLOW),
    .PERIOD_FAST (TB_FAST),
    .RAMP_STEPS  (TB_RS)
`ifdef STEP_SOFT_LIMIT_EN
    , .POS_MIN   (TB_POS_MIN)
    , .POS_MAX   (TB_POS_MAX)
`endif
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .abort      (abort),
    .step_pulse (step_pulse),
    .sentido    (sentido),
    .busy       (busy),
    .done       (done),
    .position   (position)
`ifdef STEP_SOFT_LIMIT_EN
    , .limit_hit (limit_hit)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int get_iv(input int a, input int k);
    if (k >= pulse_log.size()) return -1;
    return (k == 0) ? (pulse_log[0] - a) : (pulse_log[k] - pulse_log[k-1]);
  endfunction

  task automatic chk_ivs(input string nm, input int a, input int n);
    chk({nm, "_count"}, pulse_log.size(), n);
    for (int k = 0; k < n; k++) chk($sformatf("%s_iv%0d", nm, k), get_iv(a, k), ivs[k]);
  endtask

  task automatic plan_reset(input int r);
    for (int i = r; i < MAXC; i++) begin
      exp_pulse[i] = 1'b0; exp_done[i] = 1'b0; exp_busy[i] = 1'b0;
      exp_ready[i] = 1'b1; exp_sentido[i] = 1'b0; exp_pos[i] = '0;
`ifdef STEP_SOFT_LIMIT_EN
      exp_limit[i] = 1'b0;
`endif
    end
  endtask

  // Plans the whole move as a list of pulse cycles from the ramp rules
  task automatic plan_move(input int a, input bit dir, input int steps, input int abort_k,
                           output int e, output int abiv);
    logic [15:0] pos;
    int rem, acc, t, prev, last, k;
    bit lim;
    pos = exp_pos[a]; rem = steps; acc = 0; prev = a; last = a; k = 0; lim = 0; abiv = -1;
    for (int i = a + 1; i < MAXC; i++) begin
      exp_pulse[i] = 1'b0; exp_done[i] = 1'b0; exp_busy[i] = 1'b0;
      exp_ready[i] = 1'b1; exp_sentido[i] = dir; exp_pos[i] = pos;
`ifdef STEP_SOFT_LIMIT_EN
      exp_limit[i] = 1'b0;
`endif
    end
    if (steps == 0) begin
      exp_ready[a+1] = 1'b0; exp_done[a+1] = 1'b1; e = a + 2;
      return;
    end
    t = a + per[0];
    while (rem > 0) begin
`ifdef STEP_SOFT_LIMIT_EN
      if ((!dir && $signed(pos) >= TB_POS_MAX) || (dir && $signed(pos) <= TB_POS_MIN)) begin
        lim = 1; last = t;
        break;
      end
`endif
      if (abiv > prev && abiv <= t && rem > acc + 1) rem = acc + 1;
      exp_pulse[t] = 1'b1;
      pos = dir ? pos - 16'd1 : pos + 16'd1;
      for (int i = t + 1; i < MAXC; i++) exp_pos[i] = pos;
      rem--; k++;
      if (rem <= acc) acc = (acc > 0) ? acc - 1 : 0;
      else if (acc < TB_RS) acc++;
      if (k == abort_k) abiv = t + 1;
      prev = t; last = t;
      if (rem > 0) t += per[acc];
    end
    for (int i = a + 1; i <= last + TB_SLOW; i++) exp_busy[i] = 1'b1;
    for (int i = a + 1; i <= last + TB_SLOW + 1; i++) exp_ready[i] = 1'b0;
    exp_done[last + TB_SLOW + 1] = 1'b1;
    e = last + TB_SLOW + 2;
`ifdef STEP_SOFT_LIMIT_EN
    if (lim) for (int i = last + 1; i < MAXC; i++) exp_limit[i] = 1'b1;
`else
    if (lim) e = e + 0;
`endif
  endtask

  task automatic send(input bit dir, input int steps, input int abort_k, input bit poke,
                      output int a, output int e);
    int abiv;
    pulse_log.delete();
    done_log.delete();
    tick();
    a = cyc;
    cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = steps[15:0];
    plan_move(a, dir, steps, abort_k, e, abiv);
    tick();
    cmd_valid = 1'b0;
    if (poke) begin
      tick();
      tick();
      cmd_valid = 1'b1; cmd_dir = ~dir; cmd_steps = 16'd7;
      tick();
      cmd_valid = 1'b0;
    end
    if (abiv >= 0) begin
      while (cyc < abiv) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    while (cyc < e) tick();
  endtask

  always @(negedge CLK) begin
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget: reached %0d, limit %0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    chk("step_pulse", step_pulse, exp_pulse[cyc]);
    chk("done", done, exp_done[cyc]);
    chk("busy", busy, exp_busy[cyc]);
    chk("cmd_ready", cmd_ready, exp_ready[cyc]);
    chk("sentido", sentido, exp_sentido[cyc]);
    chk("position", position, exp_pos[cyc]);
`ifdef STEP_SOFT_LIMIT_EN
    chk("limit_hit", limit_hit, exp_limit[cyc]);
`endif
    if (step_pulse === 1'b1) pulse_log.push_back(cyc);
    if (done === 1'b1) done_log.push_back(cyc);
  end

  initial begin
    int a, e, abiv;
    for (int i = 0; i <= TB_RS; i++) per[i] = TB_SLOW - i * ((TB_SLOW - TB_FAST) / TB_RS);
    plan_reset(0);

    // Reset values, then a move interrupted by RST after three pulses
    tick();
    tick();
    RST = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_pos", position, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sentido", sentido, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_done", done, 0);
    pulse_log.delete();
    tick();
    a = cyc;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd10;
    plan_move(a, 1'b0, 10, 0, e, abiv);
    tick();
    cmd_valid = 1'b0;
    while (pulse_log.size() < 3 && cyc < a + 100) tick();
    chk("t1_pos_before_rst", position, 3);
    RST = 1'b1;
    plan_reset(cyc);
    #1;
    chk("t1_pos_in_rst", position, 0);
    chk("t1_ready_in_rst", cmd_ready, 1);
    chk("t1_busy_in_rst", busy, 0);
    tick();
    RST = 1'b0;

`ifndef STEP_SOFT_LIMIT_EN
    // Full trapezoid
    send(1'b0, 10, 0, 1'b0, a, e);
    ivs = '{20, 16, 12, 8, 4, 4, 8, 12, 16, 20};
    chk_ivs("t2", a, 10);
    chk("t2_model_end", e - a, 142);
    chk("t2_pos", position, 10);
    chk("t2_done_count", done_log.size(), 1);
    if (done_log.size() > 0 && pulse_log.size() > 0)
      chk("t2_done_gap", done_log[0] - pulse_log[pulse_log.size()-1], 21);
    else
      chk("t2_done_seen", done_log.size() * pulse_log.size(), 1);

    // Short reverse move never reaches cruise
    send(1'b1, 3, 0, 1'b0, a, e);
    ivs = '{20, 16, 20, 0, 0, 0, 0, 0, 0, 0};
    chk_ivs("t3", a, 3);
    chk("t3_pos", position, 7);
    chk("t3_sentido", sentido, 1);

    // Zero-step command
    send(1'b0, 0, 0, 1'b0, a, e);
    chk("t4_pulses", pulse_log.size(), 0);
    chk("t4_done_lat", (done_log.size() > 0) ? done_log[0] - a : -1, 1);
    chk("t4_pos", position, 7);

    // Abort at cruise, with an ignored command during the move
    send(1'b0, 100, 4, 1'b1, a, e);
    ivs = '{20, 16, 12, 8, 4, 8, 12, 16, 20, 0};
    chk_ivs("t5", a, 9);
    chk("t5_pos", position, 16);
    chk("t5_done_count", done_log.size(), 1);

    // Reverse wrap through zero
    tick();
    RST = 1'b1;
    plan_reset(cyc);
    tick();
    RST = 1'b0;
    send(1'b1, 1, 0, 1'b0, a, e);
    chk("wrap_pos", position, 16'hFFFF);
    chk("wrap_iv", get_iv(a, 0), 20);
`else
    // Soft limit at POS_MAX
    send(1'b0, 8, 0, 1'b0, a, e);
    ivs = '{20, 16, 12, 8, 4, 0, 0, 0, 0, 0};
    chk_ivs("t6", a, 5);
    chk("t6_pos", position, 5);
    chk("t6_limit", limit_hit, 1);
    chk("t6_done_count", done_log.size(), 1);
    send(1'b1, 1, 0, 1'b0, a, e);
    chk("t6_limit_clr", limit_hit, 0);
    chk("t6_pos_after", position, 4);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_motion_ctrl.md
Name: step_motion_ctrl

Overview:
Upstream command stage for the 4-coil stepper sequencer.
- Accepts move commands: direction plus step count.
- Issues one-cycle step-enable pulses on a trapezoidal accel/cruise/decel period ramp.
- Drives the sequencer's direction input and tracks absolute signed position.
- Replaces the fixed 4-speed time base when closed-count moves are required.

Parameters:
- POS_W, 16, width of step count and position.
- DIV_W, 20, width of the period timer.
- PERIOD_SLOW, 400000, CLK cycles per step at ramp start and end (must be > PERIOD_FAST).
- PERIOD_FAST, 50000, CLK cycles per step at cruise.
- RAMP_STEPS, 8, steps needed to go from slow to fast; DELTA = (PERIOD_SLOW-PERIOD_FAST)/RAMP_STEPS (localparam, integer division).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  move request
- cmd_ready  out  1  high only in IDLE
- cmd_dir  in  1  0 = forward (position +1), 1 = reverse
- cmd_steps  in  POS_W  unsigned step count
- abort  in  1  request controlled decel stop
- step_pulse  out  1  one-CLK enable to sequencer
- sentido  out  1  latched direction to sequencer
- busy  out  1  high in MOVE/SETTLE
- done  out  1  one-cycle pulse at move end
- position  out  POS_W  signed absolute position, two's complement

Behaviour:
Reset: state=IDLE; cmd_ready=1; step_pulse=0; sentido=0; busy=0; done=0; position=0; acc_idx=0; remaining=0; timer=0.

period(i) = PERIOD_SLOW - i*DELTA, with acc_idx in 0..RAMP_STEPS.

States: IDLE, MOVE, SETTLE, DONE.

IDLE:
- On cmd_valid & cmd_ready: latch sentido=cmd_dir and remaining=cmd_steps; acc_idx=0; timer=period(0).
- Go to MOVE if cmd_steps != 0, else go to DONE.

MOVE:
- timer decrements each cycle.
- When timer==1:
  - step_pulse=1 for exactly that cycle.
  - position += 1 (sentido=0) or -= 1 (sentido=1), wrapping modulo 2^POS_W.
  - remaining -= 1.
  - Ramp update, using the new remaining: if remaining <= acc_idx then acc_idx-1; else if acc_idx < RAMP_STEPS then acc_idx+1; else hold.
  - timer reloads to period(new acc_idx).
- If the new remaining == 0: go to SETTLE with timer=PERIOD_SLOW.
- Latency: first pulse exactly PERIOD_SLOW cycles after the accept cycle.

SETTLE:
- Hold the coils for PERIOD_SLOW cycles, then go to DONE.

DONE:
- done=1 for one cycle, then IDLE.

Abort:
- Sampled only in MOVE.
- Sets remaining = min(remaining, acc_idx+1) in the same cycle, which yields a ramp-down stop.
- If that cycle also has a step, the step's decrement applies to the clipped value.
- Abort in IDLE, SETTLE or DONE is ignored.

Other rules:
- cmd_valid outside IDLE is ignored, not queued.
- sentido is constant for the whole move.
- Position wraps silently (0x7FFF+1 -> 0x8000).
- RST mid-move returns everything to reset values immediately; position is lost.

Optional Feature:
Macro STEP_SOFT_LIMIT_EN.
- Defined: adds parameters POS_MIN (default -32768) and POS_MAX (default 32767) and output limit_hit (1 bit).
- A step that would take position outside [POS_MIN, POS_MAX] is suppressed: no pulse, no position change.
- The move then goes straight to SETTLE, and limit_hit is set.
- limit_hit clears on the next accepted command or on RST.
- Not defined: no limit logic and no limit_hit port; position wraps as above.

Decomposition:
- Shared package stepper_pkg: state encoding constants (IDLE=0, MOVE=1, SETTLE=2, DONE=3) and direction constants (DIR_FWD=0, DIR_REV=1).
- One natural sub-module, step_ramp_timer: owns acc_idx, period computation and the reload/terminal-count logic. It takes step and remaining and returns tick.
- The FSM, position counter and handshake live in the top module.

Test Plan:
Bench parameters: PERIOD_SLOW=20, PERIOD_FAST=4, RAMP_STEPS=4 (DELTA=4).
1. Reset -> all outputs at reset values and cmd_ready=1. Assert RST mid-move (after 3 pulses) -> position=0 and state IDLE in the same cycle.
2. cmd_steps=10, cmd_dir=0 -> pulse intervals 20,16,12,8,4,4,8,12,16,20 cycles; position=10; done 20 cycles after the last pulse (plus DONE-state cycle); busy high throughout.
3. cmd_steps=3, cmd_dir=1 from position=10 -> intervals 20,16,20 (never reaches cruise); position=7; sentido=1 for the whole move.
4. cmd_steps=0 -> accepted, no step_pulse, done asserted within 2 cycles, position unchanged.
5. cmd_steps=100; assert abort one cycle after the 4th pulse (acc_idx=4) -> exactly 5 further pulses with intervals 4,8,12,16,20; done follows; total position change +9.
6. With STEP_SOFT_LIMIT_EN, POS_MAX=5: from 0, command 8 forward -> exactly 5 pulses, limit_hit=1, done pulses, position=5. Next accepted command clears limit_hit.
